blk_com_sync_fifo_param: RTL and testbench

BLK_COM_SYNC_FIFO_PARAM -- requirements
Module: blk_com_sync_fifo_param

---
 rtl/blk_com_sync_fifo_param.sv | 112 +++++++++++
 tb/tb_blk_com_sync_fifo_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/blk_com_sync_fifo_param.sv
// Synchronous FIFO on an inferred simple dual-port RAM with registered read port,
// status flags and sticky overflow/underflow. Define COM_FIFO_PARITY_EN to store per-word even parity.
module blk_com_sync_fifo_param #(
  parameter int DATA_W   = 34,
  parameter int ADDR_W   = 15,
  parameter int AFULL_TH = 2**ADDR_W - 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              err_inj,
  input  logic              rd_en,
  input  logic              flag_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  output logic              par_err
);

  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

`ifdef COM_FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
  logic [MEM_W-1:0] wr_word;
  // Stored bit makes the whole word XOR to zero; err_inj flips it so the read side sees a mismatch.
  assign wr_word = {(^wr_data) ^ err_inj, wr_data};
`else
  localparam int MEM_W = DATA_W;
  logic [MEM_W-1:0] wr_word;
  logic             unused_err_inj;
  assign wr_word        = wr_data;
  assign unused_err_inj = err_inj;
`endif

  logic [MEM_W-1:0]  mem [2**ADDR_W];
  logic [MEM_W-1:0]  rd_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_word;
  end

  // Read stage boundary: RAM output register, valid one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) rd_q <= mem[rd_ptr];
    end
  end

  assign rd_data = rd_q[DATA_W-1:0];

`ifdef COM_FIFO_PARITY_EN
  assign par_err = rd_vld & (^rd_q);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= (AFULL_C == '0);
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      afull <= (count_nxt >= AFULL_C);
      // A new rejection event outranks a coincident clear.
      if (wr_en && full)  ovf <= 1'b1;
      else if (flag_clr)  ovf <= 1'b0;
      if (rd_en && empty) udf <= 1'b1;
      else if (flag_clr)  udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blk_com_sync_fifo_param.sv
// Bench for blk_com_sync_fifo_param (DATA_W=8, ADDR_W=4, AFULL_TH=12) against a queue-based model.
module tb_blk_com_sync_fifo_param;

  logic       clk, rst_n;
  logic       wr_en, err_inj, rd_en, flag_clr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_vld, full, empty, afull, ovf, udf, par_err;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Model state: queue entries are {err_inj, data}
  logic [8:0] mq[$];
  logic [7:0] m_data = 8'h00;
  logic       m_vld = 1'b0, m_par = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  blk_com_sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .err_inj(err_inj),
    .rd_en(rd_en), .flag_clr(flag_clr), .rd_data(rd_data), .rd_vld(rd_vld),
    .full(full), .empty(empty), .afull(afull), .count(count), .ovf(ovf), .udf(udf),
    .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == 16));
    chk({tag, ".afull"}, 32'(afull), 32'(n >= 12));
    chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(m_vld));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_data));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
    chk({tag, ".par_err"}, 32'(par_err), 32'(m_par));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = 8'h00; m_vld = 1'b0; m_par = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic e,
                      input logic r, input logic c);
    logic       wacc, racc;
    logic [8:0] ent;
    @(negedge clk);
    wr_en = w; wr_data = d; err_inj = e; rd_en = r; flag_clr = c;
    wacc = w && (mq.size() < 16);
    racc = r && (mq.size() > 0);
    if (w && mq.size() == 16) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && mq.size() == 0)  m_udf = 1'b1; else if (c) m_udf = 1'b0;
    m_vld = racc;
    m_par = 1'b0;
    if (racc) begin
      ent = mq.pop_front();
      m_data = ent[7:0];
`ifdef COM_FIFO_PARITY_EN
      m_par = ent[8];
`endif
    end
    if (wacc) mq.push_back({e, d});
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int written;
    logic w, r;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; err_inj = 1'b0; rd_en = 1'b0; flag_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Basic in-order write then read
    step("w11", 1, 8'h11, 0, 0, 0);
    step("w22", 1, 8'h22, 0, 0, 0);
    step("w33", 1, 8'h33, 0, 0, 0);
    step("r1", 0, 8'h00, 0, 1, 0);
    step("r2", 0, 8'h00, 0, 1, 0);
    step("r3", 0, 8'h00, 0, 1, 0);
    step("idle", 0, 8'h00, 0, 0, 0);

    // Fill to full, then a rejected write with a concurrent read
    for (int i = 0; i < 16; i++) step("fill", 1, 8'($urandom), 0, 0, 0);
    step("ovf_wr_rd", 1, 8'hEE, 0, 1, 0);
    step("ovf_hold", 0, 8'h00, 0, 0, 0);
    step("ovf_clr", 0, 8'h00, 0, 0, 1);
    while (mq.size() > 0) step("drain", 0, 8'h00, 0, 1, 0);

    // Read while empty with a concurrent write
    step("udf_wr_rd", 1, 8'hAA, 0, 1, 0);
    step("udf_clr", 0, 8'h00, 0, 0, 1);
    step("udf_rd", 0, 8'h00, 0, 1, 0);

    // Stream 40 words with concurrent reads across pointer wrap-around
    written = 0;
    while (written < 40) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (w && mq.size() < 16) written++;
      step("stream", w, 8'($urandom), 0, r, 0);
    end
    while (mq.size() > 0) step("stream_drain", 0, 8'h00, 0, 1, 0);

    // Unconstrained traffic including flag clears and parity injection
    for (int i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    while (mq.size() > 0) step("rand_drain", 0, 8'h00, 0, 1, 1);

    // Asynchronous reset with count=5 and a read in flight
    for (int i = 0; i < 6; i++) step("pre_rst", 1, 8'($urandom), 0, 0, 0);
    step("rst_rd", 0, 8'h00, 0, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("rst_async");
    @(negedge clk);
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("rst_release");
    step("w5c", 1, 8'h5C, 0, 0, 0);
    step("r5c", 0, 8'h00, 0, 1, 0);

    // Parity error injection on a single word
    step("w0f_err", 1, 8'h0F, 1, 0, 0);
    step("r0f_err", 0, 8'h00, 0, 1, 0);
    step("post_err", 0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
